// File: rtl/trap_pkg.sv
// Shared constants for the machine-mode trap controller: CSR numbers, cause codes,
// FSM states, mstatus bit positions and the CSR read-modify-write helper.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [1:0] CSR_OP_READ  = 2'b00;
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

  localparam logic [3:0] EXC_INSN_MISALIGN  = 4'd0;
  localparam logic [3:0] EXC_INSN_FAULT     = 4'd1;
  localparam logic [3:0] EXC_ILLEGAL_INSN   = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
  localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
  localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;
  localparam logic [3:0] EXC_ECALL_M        = 4'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Platform interrupt i reports cause code IRQ_CAUSE_BASE + i.
  localparam int IRQ_CAUSE_BASE = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAVE   = 2'd1,
    ST_VECTOR = 2'd2,
    ST_RET    = 2'd3
  } trap_state_e;

  function automatic logic [31:0] csr_apply(input logic [1:0] op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] operand);
    case (op)
      CSR_OP_WRITE: return operand;
      CSR_OP_SET:   return old_val | operand;
      CSR_OP_CLEAR: return old_val & ~operand;
      default:      return old_val;
    endcase
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Lowest-index-wins priority encoder: one-hot grant of the lowest set request bit.
module trap_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         valid
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_grant
      if (gi == 0) begin : g_first
        assign grant[gi] = req[gi];
      end else begin : g_rest
        assign grant[gi] = req[gi] & ~(|req[gi-1:0]);
      end
    end
  endgenerate

  assign valid = |req;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: M-mode CSRs, trap entry/return FSM and PC redirect.
// Define TRAP_VECTORED_EN to enable vectored interrupt dispatch (mtvec mode 01).
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          NUM_IRQ   = 4,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csr_valid,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               exc_valid,
  input  logic [3:0]         exc_code,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic [XLEN-1:0]    epc_in,
  input  logic               mret,
  output logic               flush,
  output logic               busy,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    pc_redirect
);

  localparam logic [XLEN-1:0] IRQ_MASK =
    XLEN'(((64'd1 << NUM_IRQ) - 64'd1) << IRQ_CAUSE_BASE);
  localparam logic [XLEN-1:0] MSTATUS_WMASK =
    (XLEN'(1) << MSTATUS_MIE) | (XLEN'(1) << MSTATUS_MPIE);
  localparam logic [XLEN-1:0] MSTATUS_MPP = XLEN'(3) << MSTATUS_MPP_LO;
`ifdef TRAP_VECTORED_EN
  localparam logic [XLEN-1:0] MTVEC_WMASK = '1;
`else
  localparam logic [XLEN-1:0] MTVEC_WMASK = ~XLEN'(3);
`endif

  trap_state_e state_reg, state_next;

  logic [XLEN-1:0] mstatus_reg, mie_reg, mip_reg, mtvec_reg;
  logic [XLEN-1:0] mepc_reg, mcause_reg, mtval_reg;
  logic            trap_irq_reg;
  logic [4:0]      trap_code_reg;
  logic [XLEN-1:0] trap_epc_reg, trap_tval_reg;

  logic [NUM_IRQ-1:0] irq_grant;
  logic               irq_any, irq_pending;
  logic [3:0]         irq_idx;
  logic               take_trap, save_commit, ret_restore, csr_we;
  logic [XLEN-1:0]    csr_old, csr_new, trap_base, vector_target;

  trap_prio_enc #(.N(NUM_IRQ)) u_prio (
    .req   (mip_reg[IRQ_CAUSE_BASE +: NUM_IRQ] & mie_reg[IRQ_CAUSE_BASE +: NUM_IRQ]),
    .grant (irq_grant),
    .valid (irq_any)
  );

  assign irq_pending = mstatus_reg[MSTATUS_MIE] & irq_any;

  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_grant[i]) irq_idx = 4'(i);
    end
  end

  always_comb begin
    csr_old = '0;
    case (csr_addr)
      CSR_MSTATUS: csr_old = mstatus_reg | MSTATUS_MPP;
      CSR_MIE:     csr_old = mie_reg;
      CSR_MIP:     csr_old = mip_reg;
      CSR_MTVEC:   csr_old = mtvec_reg;
      CSR_MEPC:    csr_old = mepc_reg;
      CSR_MCAUSE:  csr_old = mcause_reg;
      CSR_MTVAL:   csr_old = mtval_reg;
      default:     csr_old = '0;
    endcase
  end

  assign csr_rdata = csr_old;
  assign csr_new   = csr_apply(csr_op, csr_old, csr_wdata);

  always_comb begin
    trap_base     = {mtvec_reg[XLEN-1:2], 2'b00};
    vector_target = trap_base;
`ifdef TRAP_VECTORED_EN
    if (mtvec_reg[1:0] == 2'b01 && trap_irq_reg)
      vector_target = trap_base + (XLEN'(trap_code_reg) << 2);
`endif
  end

  always_comb begin
    state_next     = state_reg;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    pc_redirect    = '0;
    take_trap      = 1'b0;
    save_commit    = 1'b0;
    ret_restore    = 1'b0;
    csr_we         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (exc_valid || irq_pending) begin
          take_trap  = 1'b1;
          flush      = 1'b1;
          state_next = ST_SAVE;
        end else if (mret) begin
          flush      = 1'b1;
          state_next = ST_RET;
        end else if (csr_valid) begin
          csr_we = (csr_op != CSR_OP_READ);
        end
      end
      ST_SAVE: begin
        save_commit = 1'b1;
        state_next  = ST_VECTOR;
      end
      ST_VECTOR: begin
        redirect_valid = 1'b1;
        flush          = 1'b1;
        pc_redirect    = vector_target;
        state_next     = ST_IDLE;
      end
      ST_RET: begin
        redirect_valid = 1'b1;
        pc_redirect    = mepc_reg;
        ret_restore    = 1'b1;
        state_next     = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state_reg != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      mstatus_reg   <= '0;
      mie_reg       <= '0;
      mip_reg       <= '0;
      mtvec_reg     <= MTVEC_RST & MTVEC_WMASK;
      mepc_reg      <= '0;
      mcause_reg    <= '0;
      mtval_reg     <= '0;
      trap_irq_reg  <= 1'b0;
      trap_code_reg <= '0;
      trap_epc_reg  <= '0;
      trap_tval_reg <= '0;
    end else begin
      state_reg <= state_next;
      mip_reg   <= (XLEN'(irq) << IRQ_CAUSE_BASE);

      // Cause and PC are captured at acceptance; the architectural CSRs update one cycle later.
      if (take_trap) begin
        trap_irq_reg  <= ~exc_valid;
        trap_code_reg <= exc_valid ? {1'b0, exc_code} : {1'b1, irq_idx};
        trap_epc_reg  <= epc_in & ~XLEN'(3);
        trap_tval_reg <= exc_valid ? exc_tval : '0;
      end

      if (save_commit) begin
        mepc_reg                  <= trap_epc_reg;
        mcause_reg                <= {trap_irq_reg, {(XLEN-6){1'b0}}, trap_code_reg};
        mtval_reg                 <= trap_tval_reg;
        mstatus_reg[MSTATUS_MPIE] <= mstatus_reg[MSTATUS_MIE];
        mstatus_reg[MSTATUS_MIE]  <= 1'b0;
      end

      if (ret_restore) begin
        mstatus_reg[MSTATUS_MIE]  <= mstatus_reg[MSTATUS_MPIE];
        mstatus_reg[MSTATUS_MPIE] <= 1'b1;
      end

      // mip and mcause are hardware-owned; software writes to them are dropped.
      if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: mstatus_reg <= csr_new & MSTATUS_WMASK;
          CSR_MIE:     mie_reg     <= csr_new & IRQ_MASK;
          CSR_MTVEC:   mtvec_reg   <= csr_new & MTVEC_WMASK;
          CSR_MEPC:    mepc_reg    <= csr_new & ~XLEN'(3);
          CSR_MTVAL:   mtval_reg   <= csr_new;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl; expected values come from a queue scoreboard.
// Builds with or without TRAP_VECTORED_EN; vectored expectations switch on the macro.
module tb_trap_ctrl;
  import trap_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [3:0]  irq;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [31:0] exc_tval;
  logic [31:0] epc_in;
  logic        mret;
  logic        flush;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] pc_redirect;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

`ifdef TRAP_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  trap_ctrl #(.XLEN(32), .NUM_IRQ(4), .MTVEC_RST(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .irq(irq), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_tval(exc_tval), .epc_in(epc_in), .mret(mret),
    .flush(flush), .busy(busy),
    .redirect_valid(redirect_valid), .pc_redirect(pc_redirect)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one CSR access in the current cycle and returns the read data seen mid-cycle.
  task automatic do_csr(input logic [1:0] op, input logic [11:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata);
    csr_valid = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wdata;
    #4;
    rdata = csr_rdata;
    next_cycle();
    csr_valid = 1'b0; csr_op = 2'b00; csr_wdata = '0;
  endtask

  // One-shot inputs set by the caller are held for exactly one cycle; waits at most 10 cycles.
  task automatic wait_redirect(output logic flush0, output int lat,
                               output logic [31:0] pc, output logic flush_r);
    lat = -1; pc = '0; flush0 = 1'b0; flush_r = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #4;
      if (k == 0) flush0 = flush;
      if (redirect_valid && lat < 0) begin
        lat = k; pc = pc_redirect; flush_r = flush;
      end
      next_cycle();
      if (k == 0) begin
        exc_valid = 1'b0; mret = 1'b0; csr_valid = 1'b0; csr_op = 2'b00;
      end
      if (lat >= 0) break;
    end
  endtask

  task automatic test_reset();
    logic [11:0] addrs [7] = '{CSR_MSTATUS, CSR_MIE, CSR_MIP, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL};
    logic [31:0] expv [7]  = '{32'h0000_1800, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] r, e;
    rst_n = 1'b0; csr_valid = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0; irq = 0;
    exc_valid = 0; exc_code = 0; exc_tval = 0; epc_in = 0; mret = 0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    #4;
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%b exp=0", redirect_valid); end
    checks++; if (pc_redirect !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc_redirect); end
    next_cycle();
    for (int i = 0; i < 7; i++) exp_q.push_back(expv[i]);
    for (int i = 0; i < 7; i++) begin
      do_csr(CSR_OP_READ, addrs[i], 32'h0, r);
      e = exp_q.pop_front();
      checks++; if (r !== e) begin failures++; $display("FAIL reset_csr_%h got=%h exp=%h", addrs[i], r, e); end
      $display("reset read csr %h = %h", addrs[i], r);
    end
  endtask

  task automatic test_csr_ops();
    logic [1:0]  ops [18] = '{CSR_OP_WRITE, CSR_OP_SET, CSR_OP_CLEAR, CSR_OP_READ, CSR_OP_READ,
                              CSR_OP_WRITE, CSR_OP_READ, CSR_OP_WRITE, CSR_OP_READ, CSR_OP_WRITE,
                              CSR_OP_READ, CSR_OP_WRITE, CSR_OP_READ, CSR_OP_WRITE, CSR_OP_READ,
                              CSR_OP_WRITE, CSR_OP_WRITE, CSR_OP_READ};
    logic [11:0] adr [18] = '{CSR_MTVAL, CSR_MTVAL, CSR_MTVAL, CSR_MTVAL, CSR_MTVAL,
                              CSR_MEPC, CSR_MEPC, CSR_MIP, CSR_MIP, 12'h7C0,
                              12'h7C0, CSR_MTVEC, CSR_MTVEC, CSR_MIE, CSR_MIE,
                              CSR_MIE, CSR_MCAUSE, CSR_MCAUSE};
    logic [31:0] wd  [18] = '{32'hF0F0_0000, 32'h0000_00FF, 32'hF000_000F, 32'hFFFF_FFFF, 32'h0,
                              32'h0000_1003, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF,
                              32'h0, 32'h0000_0103, 32'h0, 32'hFFFF_FFFF, 32'h0,
                              32'h0, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] ex  [18] = '{32'h0, 32'hF0F0_0000, 32'hF0F0_00FF, 32'h00F0_00F0, 32'h00F0_00F0,
                              32'h0, 32'h0000_1000, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0, (VEC ? 32'h0000_0103 : 32'h0000_0100), 32'h0, 32'h000F_0000,
                              32'h000F_0000, 32'h0, 32'h0};
    logic [31:0] r, e;
    for (int i = 0; i < 18; i++) begin
      exp_q.push_back(ex[i]);
      do_csr(ops[i], adr[i], wd[i], r);
      e = exp_q.pop_front();
      checks++; if (r !== e) begin failures++; $display("FAIL csr_op_%0d got=%h exp=%h", i, r, e); end
      $display("csr op=%b addr=%h wdata=%h rdata=%h", ops[i], adr[i], wd[i], r);
    end
  endtask

  task automatic test_exception();
    logic [11:0] adr [4] = '{CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MSTATUS};
    logic [31:0] ex  [4] = '{32'h0000_0104, 32'h0000_0002, 32'hBAD0_0104, 32'h0000_1800};
    logic [31:0] r, e, pc;
    logic f0, fr;
    int lat;
    exp_q.push_back(VEC ? 32'h0000_0103 : 32'h0000_0100);
    do_csr(CSR_OP_WRITE, CSR_MTVEC, 32'h0000_0080, r);
    e = exp_q.pop_front();
    checks++; if (r !== e) begin failures++; $display("FAIL exc_mtvec_old got=%h exp=%h", r, e); end
    exc_valid = 1'b1; exc_code = EXC_ILLEGAL_INSN; epc_in = 32'h0000_0104; exc_tval = 32'hBAD0_0104;
    exp_q.push_back(32'h0000_0080);
    wait_redirect(f0, lat, pc, fr);
    e = exp_q.pop_front();
    $display("exception redirect lat=%0d pc=%h flush0=%b", lat, pc, f0);
    checks++; if (f0 !== 1'b1) begin failures++; $display("FAIL exc_flush_n got=%b exp=1", f0); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL exc_latency got=%0d exp=2", lat); end
    checks++; if (pc !== e) begin failures++; $display("FAIL exc_pc got=%h exp=%h", pc, e); end
    checks++; if (fr !== 1'b1) begin failures++; $display("FAIL exc_vector_flush got=%b exp=1", fr); end
    #4;
    checks++; if (redirect_valid !== 1'b0 || pc_redirect !== 32'h0) begin failures++;
      $display("FAIL exc_redirect_single got=%b/%h exp=0/0", redirect_valid, pc_redirect); end
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ex[i]);
      do_csr(CSR_OP_READ, adr[i], 32'h0, r);
      e = exp_q.pop_front();
      checks++; if (r !== e) begin failures++; $display("FAIL exc_csr_%h got=%h exp=%h", adr[i], r, e); end
    end
  endtask

  task automatic test_irq();
    logic [11:0] adr [4] = '{CSR_MCAUSE, CSR_MTVAL, CSR_MSTATUS, CSR_MEPC};
    logic [31:0] ex  [4] = '{32'h8000_0010, 32'h0, 32'h0000_1880, 32'h1234_5678};
    logic [31:0] r, e, pc;
    logic f0, fr;
    int lat;
    do_csr(CSR_OP_SET, CSR_MSTATUS, 32'h0000_0008, r);
    do_csr(CSR_OP_WRITE, CSR_MIE, 32'h0003_0000, r);
    do_csr(CSR_OP_WRITE, CSR_MTVEC, 32'h0000_0200, r);
    epc_in = 32'h1234_567B; irq = 4'b0011;
    exp_q.push_back(32'h0000_0200);
    wait_redirect(f0, lat, pc, fr);
    e = exp_q.pop_front();
    irq = 4'b0000; epc_in = 32'h0;
    $display("irq redirect lat=%0d pc=%h flush0=%b", lat, pc, f0);
    checks++; if (f0 !== 1'b0) begin failures++; $display("FAIL irq_unregistered_flush got=%b exp=0", f0); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL irq_latency got=%0d exp=3", lat); end
    checks++; if (pc !== e) begin failures++; $display("FAIL irq_pc got=%h exp=%h", pc, e); end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ex[i]);
      do_csr(CSR_OP_READ, adr[i], 32'h0, r);
      e = exp_q.pop_front();
      checks++; if (r !== e) begin failures++; $display("FAIL irq_csr_%h got=%h exp=%h", adr[i], r, e); end
    end
  endtask

  task automatic test_mret();
    logic [31:0] r, e, pc;
    logic f0, fr;
    int lat;
    mret = 1'b1;
    exp_q.push_back(32'h1234_5678);
    wait_redirect(f0, lat, pc, fr);
    e = exp_q.pop_front();
    $display("mret redirect lat=%0d pc=%h flush0=%b", lat, pc, f0);
    checks++; if (f0 !== 1'b1) begin failures++; $display("FAIL mret_flush got=%b exp=1", f0); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL mret_latency got=%0d exp=1", lat); end
    checks++; if (pc !== e) begin failures++; $display("FAIL mret_pc got=%h exp=%h", pc, e); end
    exp_q.push_back(32'h0000_1888);
    do_csr(CSR_OP_READ, CSR_MSTATUS, 32'h0, r);
    e = exp_q.pop_front();
    checks++; if (r !== e) begin failures++; $display("FAIL mret_mstatus got=%h exp=%h", r, e); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] adr [4] = '{CSR_MCAUSE, CSR_MIE, CSR_MEPC, CSR_MSTATUS};
    logic [31:0] ex  [4] = '{32'h0000_0005, 32'h0003_0000, 32'h0000_0300, 32'h0000_1880};
    logic [31:0] r, e, pc;
    logic f0, fr;
    int lat;
    irq = 4'b0001;
    next_cycle();
    exc_valid = 1'b1; exc_code = EXC_LOAD_FAULT; epc_in = 32'h0000_0300; exc_tval = 32'h55;
    csr_valid = 1'b1; csr_op = CSR_OP_WRITE; csr_addr = CSR_MIE; csr_wdata = 32'h0;
    exp_q.push_back(32'h0000_0200);
    wait_redirect(f0, lat, pc, fr);
    e = exp_q.pop_front();
    irq = 4'b0000;
    $display("priority redirect lat=%0d pc=%h flush0=%b", lat, pc, f0);
    checks++; if (lat !== 2) begin failures++; $display("FAIL prio_latency got=%0d exp=2", lat); end
    checks++; if (pc !== e) begin failures++; $display("FAIL prio_pc got=%h exp=%h", pc, e); end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ex[i]);
      do_csr(CSR_OP_READ, adr[i], 32'h0, r);
      e = exp_q.pop_front();
      checks++; if (r !== e) begin failures++; $display("FAIL prio_csr_%h got=%h exp=%h", adr[i], r, e); end
    end
  endtask

  task automatic test_reset_in_save();
    logic [11:0] adr [6] = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL};
    logic [31:0] r, e;
    logic seen, nz;
    exc_valid = 1'b1; exc_code = EXC_STORE_FAULT; epc_in = 32'h0000_0400; exc_tval = 32'h77;
    #4;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rsave_flush got=%b exp=1", flush); end
    next_cycle();
    exc_valid = 1'b0;
    #4;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rsave_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    seen = 1'b0; nz = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #4;
      if (redirect_valid) seen = 1'b1;
      if (pc_redirect !== 32'h0) nz = 1'b1;
      next_cycle();
    end
    $display("reset in save: redirect_seen=%b", seen);
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rsave_redirect got=%b exp=0", seen); end
    checks++; if (nz !== 1'b0) begin failures++; $display("FAIL rsave_pc_nonzero got=%b exp=0", nz); end
    for (int i = 0; i < 6; i++) exp_q.push_back(i == 0 ? 32'h0000_1800 : 32'h0);
    for (int i = 0; i < 6; i++) begin
      do_csr(CSR_OP_READ, adr[i], 32'h0, r);
      e = exp_q.pop_front();
      checks++; if (r !== e) begin failures++; $display("FAIL rsave_csr_%h got=%h exp=%h", adr[i], r, e); end
    end
  endtask

  task automatic test_vectored();
    logic [31:0] r, e, pc;
    logic f0, fr;
    int lat;
    do_csr(CSR_OP_WRITE, CSR_MTVEC, 32'h0000_0101, r);
    exp_q.push_back(VEC ? 32'h0000_0101 : 32'h0000_0100);
    do_csr(CSR_OP_READ, CSR_MTVEC, 32'h0, r);
    e = exp_q.pop_front();
    checks++; if (r !== e) begin failures++; $display("FAIL vec_mtvec got=%h exp=%h", r, e); end
    do_csr(CSR_OP_SET, CSR_MSTATUS, 32'h0000_0008, r);
    do_csr(CSR_OP_WRITE, CSR_MIE, 32'h0001_0000, r);
    irq = 4'b0001;
    exp_q.push_back(VEC ? 32'h0000_0140 : 32'h0000_0100);
    wait_redirect(f0, lat, pc, fr);
    e = exp_q.pop_front();
    irq = 4'b0000;
    $display("vectored irq redirect lat=%0d pc=%h", lat, pc);
    checks++; if (lat !== 3) begin failures++; $display("FAIL vec_irq_latency got=%0d exp=3", lat); end
    checks++; if (pc !== e) begin failures++; $display("FAIL vec_irq_pc got=%h exp=%h", pc, e); end
    exc_valid = 1'b1; exc_code = EXC_ECALL_M; epc_in = 32'h0000_0500; exc_tval = 32'h0;
    exp_q.push_back(32'h0000_0100);
    wait_redirect(f0, lat, pc, fr);
    e = exp_q.pop_front();
    $display("vectored exc redirect lat=%0d pc=%h", lat, pc);
    checks++; if (pc !== e) begin failures++; $display("FAIL vec_exc_pc got=%h exp=%h", pc, e); end
  endtask

  initial begin
    test_reset();
    test_csr_ops();
    test_exception();
    test_irq();
    test_mret();
    test_back_to_back();
    test_reset_in_save();
    test_vectored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (only 32 supported).
REQ-002 SHALL have parameter NUM_IRQ, default 4, number of platform interrupt lines, legal range 1..16.
REQ-003 SHALL have parameter MTVEC_RST, default 32'h0000_0000, reset value of mtvec.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- csr_valid  in  1  CSR instruction present.
- csr_op  in  2  01 write, 10 set, 11 clear, 00 read-only.
- csr_addr  in  12  CSR number.
- csr_wdata  in  XLEN  write/set/clear operand, already imm-muxed.
- csr_rdata  out  XLEN  old value of the addressed CSR.
- irq  in  NUM_IRQ  level-sensitive interrupt lines.
- exc_valid  in  1  synchronous exception at the commit stage.
- exc_code  in  4  exception cause code.
- exc_tval  in  XLEN  faulting address or instruction.
- epc_in  in  XLEN  PC of the committing instruction.
- mret  in  1  MRET at the commit stage.
- flush  out  1  kill all pipeline registers.
- busy  out  1  stall the commit stage.
- redirect_valid  out  1  one-cycle PC redirect strobe.
- pc_redirect  out  XLEN  redirect target.

Function
REQ-006 SHALL implement mstatus (MIE bit 3, MPIE bit 7, MPP bits 12:11 hardwired 11), mie, mip, mtvec, mepc, mcause and mtval at 0x300, 0x304, 0x344, 0x305, 0x341, 0x342 and 0x343.
REQ-007 SHALL run an FSM with states IDLE, SAVE, VECTOR and RET; busy SHALL be 1 in every state except IDLE.
REQ-008 In IDLE, events SHALL be resolved in priority order exc_valid > pending interrupt > mret > csr_valid; exactly one event is accepted per cycle.
REQ-009 mip[16+i] SHALL equal irq[i] registered once; an interrupt is pending when mstatus.MIE = 1 and (mip & mie) != 0. When several are pending, the lowest i wins.
REQ-010 Accepting a trap in cycle N:
- flush = 1 combinationally in cycle N.
- At edge N+1, the FSM goes to SAVE and latches the cause and epc_in.
REQ-011 In SAVE, the following SHALL be written at edge N+2, and the FSM goes to VECTOR:
- mepc = epc_in with bits 1:0 cleared.
- mcause = {0, exc_code} for an exception, or {1, 16+i} for an interrupt.
- mtval = exc_tval for an exception, or 0 for an interrupt.
- mstatus: MPIE = MIE, then MIE = 0.
REQ-012 In VECTOR:
- redirect_valid = 1 and flush = 1 for exactly one cycle.
- pc_redirect = {mtvec[31:2], 00}.
- FSM returns to IDLE.
REQ-013 An accepted mret SHALL assert flush in the same cycle. The FSM goes to RET, which:
- drives redirect_valid = 1 and pc_redirect = mepc for one cycle;
- writes MIE = MPIE and MPIE = 1;
- returns to IDLE.
REQ-014 A CSR access (csr_valid in IDLE with no higher-priority event) SHALL complete in that cycle:
- csr_rdata = old value.
- Write, set or clear applied at the next edge.
- csr_op 00 causes no write.
REQ-015 Writes to mip and to the mcause/mepc low bits SHALL be ignored. Unimplemented addresses read 0 and ignore writes.
REQ-016 csr_valid, mret and exc_valid SHALL be ignored while busy = 1. irq changes during busy take effect only after the return to IDLE.
REQ-017 pc_redirect SHALL be 0 whenever redirect_valid = 0.

Reset
REQ-018 When rst_n = 0 at a rising edge:
- FSM goes to IDLE.
- flush, busy and redirect_valid become 0.
- mstatus.MIE = 0, MPIE = 0; mie = 0; mip = 0.
- mtvec = MTVEC_RST; mepc, mcause and mtval = 0.
REQ-019 Reset during SAVE, VECTOR or RET SHALL abort the sequence with no redirect issued.

Configuration
REQ-020 With TRAP_VECTORED_EN defined:
- mtvec[1:0] = 01 selects vectored mode.
- Interrupt redirects go to base + 4*(mcause[3:0] + 16 for the irq range, i.e. the cause code).
- Exceptions always go to base.
REQ-021 Without TRAP_VECTORED_EN, mtvec[1:0] SHALL read 00, writes to those bits are ignored, and every redirect goes to base.

Structure
REQ-022 Package trap_pkg SHALL hold:
- CSR address constants;
- exception cause codes;
- the FSM state enum;
- mstatus bit indices.
REQ-023 Interrupt selection SHALL be a sub-module trap_prio_enc (NUM_IRQ-wide one-hot-lowest with valid output).

Verification
REQ-024 The bench SHALL cover these scenarios:
- Write 0x80 to mtvec, then exc_valid with exc_code = 2 and epc_in = 0x104. Response: flush in cycle N; at N+2 mepc = 0x104, mcause = 0x2; in cycle N+2 redirect_valid = 1 with pc_redirect = 0x80.
- Set MIE, mie[17:16] = 11, raise irq[1:0] = 11. Response: mcause = 0x8000_0010, mtval = 0, MIE = 0, MPIE = 1.
- mret after a trap. Response: redirect to mepc, MIE restored to 1, MPIE = 1.
- exc_valid, irq and csr_valid in the same cycle. Response: exception taken, CSR write dropped.
- Reset asserted in SAVE. Response: no redirect_valid; all registers at reset values.
- TRAP_VECTORED_EN defined with mtvec = 0x101 and irq[0]. Response: pc_redirect = 0x140.
